// File: rtl/seven_segment_pkg.sv
// Shared constants and hex-to-segment decode for the seven-segment display driver.
// Segment encoding is active-low, bit 0 = A through bit 6 = G.
package seven_segment_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry 15 (F) first down to entry 0
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(nibble_i);

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed, double-buffered driver for a common-anode hex display.
// Optional leading-zero blanking when SEVEN_SEGMENT_MUX_LZB_EN is defined.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_COUNT = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d, act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_end, frame_end;
  logic [NUM_DIGITS-1:0]   blank_eff;
  logic [3:0]              cur_nib;
  logic                    cur_blank, cur_dp;
  logic [6:0]              dec_seg;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    pending_d   = pending_q;
    sh_data_d   = sh_data_q;
    sh_dp_d     = sh_dp_q;
    sh_blank_d  = sh_blank_q;
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      sh_data_d  = data_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      pending_d  = 1'b1;
    end

    // A load landing on the frame boundary bypasses the shadow stage
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        act_data_d  = data_in;
        act_dp_d    = dp_in;
        act_blank_d = blank_in;
      end else if (pending_q) begin
        act_data_d  = sh_data_q;
        act_dp_d    = sh_dp_q;
        act_blank_d = sh_blank_q;
      end
    end
  end

  always_comb begin
    blank_eff = act_blank_q;
`ifdef SEVEN_SEGMENT_MUX_LZB_EN
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if ((act_data_q >> (4 * k)) == '0) blank_eff[k] = 1'b1;
    end
`endif
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib   = act_data_q[4*k +: 4];
        cur_blank = blank_eff[k];
        cur_dp    = act_dp_q[k];
      end
    end
  end

  seg7_hex_decode u_decode (
    .nibble_i (cur_nib),
    .seg_o    (dec_seg)
  );

  always_comb begin
    anode_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k) && !cur_blank) anode_d[k] = 1'b0;
    end
    seg_d = cur_blank ? SEG_OFF : dec_seg;
    dp_d  = ~(cur_dp & ~cur_blank);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pending_q   <= 1'b0;
      sh_data_q   <= '0;
      sh_dp_q     <= '0;
      sh_blank_q  <= '0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '0;
      anode_q     <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      sh_data_q   <= sh_data_d;
      sh_dp_q     <= sh_dp_d;
      sh_blank_q  <= sh_blank_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      anode_q     <= anode_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign anode      = anode_q;
  assign segment    = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_end;

endmodule
